// File: rtl/rle_decoder_pkg.sv
// Shared constants and FSM state encoding for the run-length coefficient decoder.
// Pure declarations: no latency, no flow control.
package rle_decoder_pkg;
    localparam int COEF_W_DEF = 8;
    localparam int RUN_W_DEF  = 4;
    localparam int BLK_SIZE   = 64;
    localparam int ROW_SIZE   = 8;
    localparam int POS_W      = $clog2(BLK_SIZE);
    localparam int COL_W      = $clog2(ROW_SIZE);

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_RUN,
        ST_VAL,
        ST_FILL
    } state_t;
endpackage

// File: rtl/rle_row_buf.sv
// Row assembly buffer plus output row register; a row leaves one cycle after its col-7 write.
// A col-7 write stalls while a previous row is unconsumed; drain and reload can share one edge.
module rle_row_buf
    import rle_decoder_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_wr_en,
    input  logic [COL_W-1:0]           i_wr_col,
    input  logic                       i_wr_last_row,
    input  logic [COEF_W-1:0]          i_wr_dat,
    output logic                       o_stall,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [ROW_SIZE*COEF_W-1:0] o_out_data,
    output logic                       o_out_last
);
    logic [COEF_W-1:0]          r_buf [0:ROW_SIZE-2];
    logic [ROW_SIZE*COEF_W-1:0] r_out_data;
    logic                       r_out_valid;
    logic                       r_out_last;
    logic                       w_row_end;
    logic                       w_wr;
    logic [ROW_SIZE*COEF_W-1:0] w_row;

    assign w_row_end = i_wr_en && (i_wr_col == COL_W'(ROW_SIZE-1));
    assign o_stall   = w_row_end && r_out_valid && !i_out_ready;
    assign w_wr      = i_wr_en && !o_stall;

    // Column 7 bypasses the buffer straight into the output register.
    always_comb begin
        w_row = '0;
        for (int i = 0; i < ROW_SIZE-1; i++) begin
            w_row[(ROW_SIZE-i)*COEF_W-1 -: COEF_W] = r_buf[i];
        end
        w_row[COEF_W-1:0] = i_wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROW_SIZE-1; i++) begin
                r_buf[i] <= '0;
            end
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_wr && !w_row_end) begin
                r_buf[i_wr_col] <= i_wr_dat;
            end
            if (w_wr && w_row_end) begin
                r_out_data  <= w_row;
                r_out_valid <= 1'b1;
                r_out_last  <= i_wr_last_row;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_out_last  = r_out_last;
endmodule

// File: rtl/rle_decoder.sv
// Expands {run,value}/EOB symbols into 8x8 coefficient blocks, one coefficient per cycle, emitted as rows.
// First coefficient written 1 cycle after accept; a full output row stalls the FSM and sym_ready stays low.
module rle_decoder
    import rle_decoder_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEF,
    parameter int RUN_W  = RUN_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sym_valid,
    output logic                       sym_ready,
    input  logic [RUN_W+COEF_W-1:0]    sym_data,
    input  logic                       sym_eob,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ROW_SIZE*COEF_W-1:0] out_data,
    output logic                       out_last
);
    state_t             r_state;
    logic [POS_W-1:0]   r_pos;
    logic [RUN_W-1:0]   r_cnt;
    logic [COEF_W-1:0]  r_val;
    logic               r_sym_ready;

    logic [RUN_W-1:0]   w_run;
    logic [COEF_W-1:0]  w_value;
    logic               w_accept;
    logic               w_wr_en;
    logic [COEF_W-1:0]  w_wr_dat;
    logic               w_stall;

    assign w_run    = sym_data[RUN_W+COEF_W-1 -: RUN_W];
    assign w_value  = sym_data[COEF_W-1:0];
    assign w_accept = sym_valid && r_sym_ready;
    assign w_wr_en  = (r_state != ST_FETCH);
    assign w_wr_dat = (r_state == ST_VAL) ? r_val : '0;

    // sym_ready is registered so it stays low throughout reset and rises on the first edge after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FETCH;
            r_pos       <= '0;
            r_cnt       <= '0;
            r_val       <= '0;
            r_sym_ready <= 1'b0;
        end else if (!w_stall) begin
            case (r_state)
                ST_FETCH: begin
                    if (w_accept) begin
                        r_sym_ready <= 1'b0;
                        r_val       <= w_value;
                        if (sym_eob) begin
                            r_state <= ST_FILL;
                        end else if (w_run != '0) begin
                            r_cnt   <= w_run;
                            r_state <= ST_RUN;
                        end else begin
                            r_state <= ST_VAL;
                        end
                    end else begin
                        r_sym_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_pos <= r_pos + 1'b1;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == RUN_W'(1)) begin
                        r_state <= ST_VAL;
                    end
                end
                ST_VAL: begin
                    r_pos       <= r_pos + 1'b1;
                    r_state     <= ST_FETCH;
                    r_sym_ready <= 1'b1;
                end
                ST_FILL: begin
                    r_pos <= r_pos + 1'b1;
                    if (r_pos == POS_W'(BLK_SIZE-1)) begin
                        r_state     <= ST_FETCH;
                        r_sym_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    assign sym_ready = r_sym_ready;

    rle_row_buf #(
        .COEF_W (COEF_W)
    ) u_row_buf (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_wr_en       (w_wr_en),
        .i_wr_col      (r_pos[COL_W-1:0]),
        .i_wr_last_row (r_pos[POS_W-1:COL_W] == COL_W'(ROW_SIZE-1)),
        .i_wr_dat      (w_wr_dat),
        .o_stall       (w_stall),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_data    (out_data),
        .o_out_last    (out_last)
    );
endmodule

// File: doc/rle_decoder.md
RLE_DECODER -- requirements
Module: rle_decoder

Interface
REQ-001 Parameter COEF_W, default 8, coefficient width in bits.
REQ-002 Parameter RUN_W, default 4, run-length field width in bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 sym_valid  input  1  symbol present.
REQ-006 sym_ready  output  1  decoder accepts symbol this cycle.
REQ-007 sym_data  input  RUN_W+COEF_W  {run, value}; run in MSBs.
REQ-008 sym_eob  input  1  end-of-block marker; sym_data ignored when set.
REQ-009 out_valid  output  1  out_data holds a complete row.
REQ-010 out_ready  input  1  downstream accepts row.
REQ-011 out_data  output  8*COEF_W  8 coefficients; first in scan order in MSBs [8*COEF_W-1 -: COEF_W].
REQ-012 out_last  output  1  out_data is row 7 (final row) of a 64-coefficient block.

Function
REQ-013 Transfers occur on valid&&ready at a rising edge, on both ports.
REQ-014 Coefficients are written one per cycle into a row buffer at column col (0..7); row index row (0..7); block position pos = {row,col}.
REQ-015 States: FETCH, RUN, VAL, FILL; sym_ready=1 only in FETCH with no stall.
REQ-016 FETCH, accept with sym_eob=1 -> FILL.
REQ-017 FETCH, accept with sym_eob=0, run>0 -> RUN, zero counter loaded with run.
REQ-018 FETCH, accept with sym_eob=0, run=0 -> VAL.
REQ-019 RUN writes one zero per cycle, decrements counter, goes to VAL after writing the last zero.
REQ-020 VAL writes latched value (including value 0), then -> FETCH.
REQ-021 FILL writes one zero per cycle until pos 63 is written, then -> FETCH; EOB at pos 0 yields 64 zeros.
REQ-022 Writing pos 63 in any state ends the block: pos wraps to 0; no EOB is required after a nonzero coefficient at pos 63.
REQ-023 A run crossing pos 63 continues into the next block (no error, no discard).
REQ-024 A write to col 7 transfers the completed row to the output register the same edge; out_valid rises next cycle with out_last = (row==7).
REQ-025 Stall: a col-7 write is held (no state, counter or buffer change) while out_valid=1 and out_ready=0.
REQ-026 Simultaneous out drain and col-7 write: the new row is loaded, out_valid stays 1, no bubble.
REQ-027 out_data, out_last stable while out_valid=1 and out_ready=0.
REQ-028 Latency: accepted symbol run=r, first coefficient written 1 cycle after accept; value written r+1 cycles after accept, absent stalls.
REQ-029 Throughput: one coefficient per cycle sustained with out_ready held 1.

Reset
REQ-030 rst_n low asynchronously forces: state FETCH, pos 0, zero counter 0, row buffer 0, out_valid 0, out_data 0, out_last 0, sym_ready 0.
REQ-031 sym_ready may assert on the first edge after rst_n deasserts; a reset mid-block discards the partial block and any pending output row.

Structure
REQ-032 Shared package holds COEF_W, RUN_W defaults, block size 64, row size 8, and the state enumeration.
REQ-033 One sub-module, rle_row_buf: row buffer plus output register with valid/ready and stall logic; FSM and counters stay in rle_decoder.

Verification
REQ-034 Symbols {0,0x05},{2,0x03},EOB -> row0 = 05,00,00,03,00,00,00,00; rows 1-7 zero; out_last on 8th row only.
REQ-035 Single EOB from reset -> 8 all-zero rows, out_last=1 on 8th, sym_ready low during 64 fill cycles.
REQ-036 64 symbols {0,k} k=1..64 (COEF_W=8), no EOB -> rows 01..08 ... 39..40 hex, second block starts at pos 0.
REQ-037 Symbol {15,0x00} then {0,0x07},EOB -> 16 zeros, 0x07 at pos 16, rest zero.
REQ-038 out_ready held 0 after first row -> decoder stalls at col 7 of row 1, out_data unchanged; release -> rows delivered in order, none lost.
REQ-039 rst_n pulsed low mid-RUN -> all outputs 0 within reset, next block decodes correctly from pos 0.
